// File: rtl/prll_bs_pkg.sv
// prll_bs_pkg: shared constants and helpers for the parallel bus driver blocks
package prll_bs_pkg;
  localparam logic [7:0] BCAST_ID = 8'hFF;
  localparam int DEST_W = 8;

  function automatic int dest_lsb(input int bits);
    return bits - DEST_W;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/prll_bs_fifo_mem.sv
// prll_bs_fifo_mem: dual-port register array, synchronous write, asynchronous read
module prll_bs_fifo_mem import prll_bs_pkg::*; #(
  parameter int bits = 32,
  parameter int depth = 16,
  parameter int aw = ptr_w(depth)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [aw-1:0]   wa,
  input  logic [bits-1:0] wd,
  input  logic [aw-1:0]   ra,
  output logic [bits-1:0] rd
);
  logic [bits-1:0] mem [depth];
  // write port; contents are intentionally left uninitialised
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/prll_bs_drvr_fifo.sv
// prll_bs_drvr_fifo: per-driver first-word-fall-through FIFO feeding the bus arbiter
module prll_bs_drvr_fifo import prll_bs_pkg::*; #(
  parameter int bits = 32,
  parameter int depth = 16,
  parameter int almost_full_lvl = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [bits-1:0]           D_push,
  input  logic                      pop,
  output logic [bits-1:0]           D_pop,
  output logic                      pndng,
  output logic                      full,
  output logic                      almost_full,
  output logic [$clog2(depth):0]    count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);
  localparam int aw = ptr_w(depth);
  localparam int cw = aw + 1;

  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("prll_bs_drvr_fifo: depth must be a power of two and at least 2");
  end
  if (almost_full_lvl < 1 || almost_full_lvl > depth) begin : g_bad_afl
    $error("prll_bs_drvr_fifo: almost_full_lvl must be in 1..depth");
  end

  logic [aw-1:0]   wp, rp;
  logic [bits-1:0] rd;
  logic            pop_eff, push_ok;

  assign pndng       = count != '0;
  assign full        = count == cw'(depth);
  assign almost_full = count >= cw'(almost_full_lvl);
  assign pop_eff     = pop && pndng;
  assign push_ok     = push && (!full || pop_eff);
  assign D_pop       = pndng ? rd : '0;

  prll_bs_fifo_mem #(.bits(bits), .depth(depth)) u_mem (
    .clk(clk),
    .we(push_ok),
    .wa(wp),
    .wd(D_push),
    .ra(rp),
    .rd(rd)
  );

  // pointers, occupancy and sticky error flags; a new error beats clr_err
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + aw'(1);
      if (pop_eff) rp <= rp + aw'(1);
      count     <= count + cw'(push_ok) - cw'(pop_eff);
      overflow  <= (overflow && !clr_err) || (push && !push_ok);
      underflow <= (underflow && !clr_err) || (pop && !pndng);
    end
endmodule

// File: tb/tb_prll_bs_drvr_fifo.sv
// tb_prll_bs_drvr_fifo: scoreboard bench for the driver FIFO
module tb_prll_bs_drvr_fifo;
  localparam int DEPTH = 16;
  localparam int AFL = 12;

  logic        clk = 0;
  logic        reset = 1;
  logic        push = 0, pop = 0, clr_err = 0;
  logic [31:0] D_push = '0;
  logic [31:0] D_pop;
  logic        pndng, full, almost_full, overflow, underflow;
  logic [4:0]  count;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] sb[$];
  logic exp_ovf = 0, exp_unf = 0;

  prll_bs_drvr_fifo #(.bits(32), .depth(DEPTH), .almost_full_lvl(AFL)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    chk("count", 32'(count), 32'(sb.size()));
    chk("pndng", 32'(pndng), 32'(sb.size() != 0));
    chk("full", 32'(full), 32'(sb.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(sb.size() >= AFL));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
  endtask

  task automatic cyc(input logic p, input logic [31:0] d, input logic q, input logic c);
    logic had, acc;
    logic [31:0] tmp;
    had = sb.size() != 0;
    push = p; D_push = d; pop = q; clr_err = c;
    if (had && q) chk("d_pop", D_pop, sb[0]);
    if (!had) chk("d_pop_empty", D_pop, 32'h0);
    acc = p && (sb.size() < DEPTH || (q && had));
    exp_ovf = (exp_ovf && !c) || (p && !acc);
    exp_unf = (exp_unf && !c) || (q && !had);
    if (q && had) tmp = sb.pop_front();
    if (acc) sb.push_back(d);
    @(posedge clk); #1;
    push = 0; pop = 0; clr_err = 0;
    chk_status();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_status();
    chk("d_pop_reset", D_pop, 32'h0);
    reset = 0;
    @(posedge clk); #1;

    cyc(1, 32'hA1, 0, 0);
    chk("d_pop_first", D_pop, 32'hA1);
    cyc(1, 32'hB2, 0, 0);
    cyc(1, 32'hC3, 0, 0);
    repeat (3) cyc(0, 0, 1, 0);

    for (int i = 0; i < DEPTH; i++) cyc(1, 32'(i), 0, 0);
    cyc(1, 32'hFF, 0, 0);
    cyc(1, 32'h55, 1, 0);
    chk("d_pop_head_adv", D_pop, 32'h1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);

    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 32'h99, 1, 0);
    cyc(0, 0, 1, 1);

    cyc(1, 32'd1000, 0, 0);
    for (int i = 1; i <= 40; i++) cyc(1, 32'(1000 + i), 1, 0);
    cyc(0, 0, 1, 0);

    for (int i = 0; i < 5; i++) cyc(1, 32'(32'h300 + i), 0, 0);
    #2 reset = 1;
    #1;
    chk("async_pndng", 32'(pndng), 32'h0);
    chk("async_count", 32'(count), 32'h0);
    chk("async_full", 32'(full), 32'h0);
    sb.delete();
    exp_ovf = 0; exp_unf = 0;
    @(posedge clk); #1;
    reset = 0;
    cyc(1, 32'h77, 0, 0);
    chk("d_pop_after_reset", D_pop, 32'h77);
    cyc(0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prll_bs_drvr_fifo.md
# prll_bs_drvr_fifo

Per-driver first-word-fall-through FIFO that sits directly upstream of the parallel bus generator/arbiter. A driver-side producer writes words with `push`/`D_push`; the arbiter sees `pndng` and `D_pop`, and consumes words with `pop`. One instance is used per driver per bus. The same block also serves as the receive-side sink for the arbiter's `push`/`D_push`.

## Interface
- `bits`, default 32: word width; the upper 8 bits carry the destination ID, and the block does not interpret them.
- `depth`, default 16: number of entries; must be a power of two and at least 2.
- `almost_full_lvl`, default 12: occupancy at which `almost_full` asserts; range 1..depth.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `push`, in, 1: write request; `D_push` is written when accepted.
- `D_push`, in, bits: write data.
- `pop`, in, 1: read request from the arbiter.
- `D_pop`, out, bits: head-of-FIFO word; valid whenever `pndng`=1.
- `pndng`, out, 1: FIFO is non-empty.
- `full`, out, 1: count equals depth.
- `almost_full`, out, 1: count is at least almost_full_lvl.
- `count`, out, $clog2(depth)+1: current occupancy, from 0 to depth.
- `overflow`, out, 1: sticky; a push was dropped.
- `underflow`, out, 1: sticky; a pop arrived while empty.
- `clr_err`, in, 1: synchronous clear of `overflow` and `underflow`.

## Operation
- **Storage:** circular buffer with write pointer `wp` and read pointer `rp`, each $clog2(depth) bits, wrapping modulo depth. The occupancy counter `count` is held separately so that full and empty are unambiguous.
- **Push accepted when:** `push` && (!full || pop_eff), where pop_eff = `pop` && `pndng`.
- **Accepted push:** writes `D_push` at `wp`, then `wp` increments.
- **Pop accepted when:** `pop` && `pndng`. An accepted pop increments `rp`.
- **Count update:** +1 on push only, −1 on pop only, unchanged when both are accepted or neither is.
- **Dropped push:** `push` while full without an accepted pop. Data is discarded; state is unchanged except that `overflow` is set.
- **Empty pop:** `pop` while `pndng`=0. Ignored, and `underflow` is set.
- **Error flags:** `clr_err` clears both flags. If a new error occurs in the same cycle as `clr_err`, the set wins.
- **Simultaneous push and pop:**
  - When empty: the push is accepted and the pop is an underflow; no bypass, so the word is not returned that cycle.
  - When full: both are accepted; count stays at depth, and `full` stays 1.
- **`D_pop` output:** always mem[`rp`]. Its value is don't-care when `pndng`=0, but it must not be X after reset; the memory may stay uninitialised, but `D_pop` is gated to 0 when empty.

## Timing
- **Reset values:** `wp`=`rp`=0, `count`=0, `pndng`=0, `full`=0, `almost_full`=0 (1 only if almost_full_lvl=0, which is illegal), `overflow`=`underflow`=0, `D_pop`=0.
- **Push to visible:** a push into an empty FIFO in cycle N gives `pndng`=1 with the word on `D_pop` in cycle N+1.
- **Pop to next word:** a pop in cycle N presents the next word, or `pndng`=0, in cycle N+1.
- **Status outputs:** `pndng`, `full`, `almost_full` and `count` are registered or derived from registered `count` only. There is no combinational path from `push` or `pop` to any output.
- **Throughput:** sustained one push and one pop per cycle with no bubbles.
- **Reset mid-operation:** asserting `reset` at any time immediately empties the FIFO and deasserts `pndng` without waiting for a clock edge. Queued data is lost. After `reset` is released, the first push is visible one cycle later.

## Structure
- **Shared package `prll_bs_pkg`:**
  - broadcast ID constant 8'hFF;
  - destination-field width 8 and its position (msb-aligned in the `bits`-wide word);
  - a function computing pointer width from depth.
- **Sub-module `prll_bs_fifo_mem`:** simple dual-port register array with synchronous write and asynchronous read, parameterised by bits and depth. It is kept separate so the array can later be swapped for inferred BRAM.
- **Top level:** pointers, count, flags and elaboration-time parameter checks (depth a power of two, almost_full_lvl in range).

## Test plan
- **Basic ordering:** after reset, push 0xA1, 0xB2, 0xC3 on consecutive cycles, then pop three times. Required: `D_pop` sequence A1, B2, C3; `count` goes 1, 2, 3, then 2, 1, 0; `pndng`=0 after the last pop.
- **Fill and overflow** (depth=16, almost_full_lvl=12): push 0..15. Required: `almost_full` rises when `count`=12, `full`=1 at 16. A 17th push of 0xFF is dropped and `overflow`=1. Popping all 16 words returns 0..15.
- **Simultaneous at full:** with the FIFO full, push 0x55 and pop in the same cycle. Required: `count` stays 16, the head advances, and 0x55 emerges as the 16th pop.
- **Underflow:** pop while empty. Required: `underflow`=1 and `count` stays 0. Then `clr_err` clears it; `clr_err` together with another empty pop leaves `underflow`=1.
- **Wrap-around:** 40 cycles of continuous push and pop of an incrementing value, starting from 1 queued word. Required: output is in-order with no loss and `count` is constant at 1.
- **Async reset mid-stream:** assert `reset` between clock edges with 5 words queued. Required: `pndng`, `count` and `full` go to 0 before the next edge; after release, push 0x77 gives `D_pop`=0x77 one cycle later.
